// File: rtl/pe_inj_queue_pkg.sv
// Shared definitions for the PE injection queue.
package pe_inj_queue_pkg;

    localparam int DEF_P_W   = 16;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    // Queue operation for one cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Occupancy needs one extra bit so that full and empty stay distinct.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pe_inj_queue_fifo.sv
// First-word fall-through storage for the injection queue.
// Pointers wrap modulo DEPTH; the occupancy counter tells full from empty.
module pe_fifo
    import pe_inj_queue_pkg::*;
#(
    parameter int P_W   = DEF_P_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [P_W-1:0]         wr_data,
    output logic [P_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [P_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    occ_r;
    fifo_op_e       op_s;

    assign op_s = fifo_op_e'({push, pop});

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= {(AW+1){1'b0}};
        end else begin
            case (op_s)
                OP_PUSH: begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                    occ_r    <= occ_r + (AW+1)'(1);
                end
                OP_POP: begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                    occ_r    <= occ_r - (AW+1)'(1);
                end
                OP_BOTH: begin
                    wr_ptr_r <= wr_ptr_r + AW'(1);
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign rd_data   = mem_r[rd_ptr_r];
    assign occupancy = occ_r;

endmodule

// File: rtl/pe_inj_queue.sv
// Injection queue between a torus PE and its Hoplite switch injection port.
// Self-addressed packets bypass the queue onto a one-cycle loopback port.
module pe_inj_queue
    import pe_inj_queue_pkg::*;
#(
    parameter int P_W   = DEF_P_W,
    parameter int X_AW  = 2,
    parameter int Y_AW  = 2,
    parameter int X_POS = 0,
    parameter int Y_POS = 0,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [P_W-1:0]         pe_pkt,
    input  logic                   pe_vld,
    output logic                   pe_rdy,
    output logic [P_W-1:0]         sw_pkt,
    output logic                   sw_vld,
    input  logic                   sw_rdy,
    output logic [P_W-1:0]         lb_pkt,
    output logic                   lb_vld,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       inj_cnt,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [X_AW-1:0]  dest_x_s;
    logic [Y_AW-1:0]  dest_y_s;
    logic             self_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             stall_s;
    logic [P_W-1:0]   head_s;
    logic [OCC_W-1:0] occ_s;
    logic [P_W-1:0]   lb_pkt_r;
    logic             lb_vld_r;
    logic [CNT_W-1:0] inj_cnt_r;
    logic [CNT_W-1:0] stall_cnt_r;

    // Destination fields sit in the packet MSBs: {dest_x, dest_y, data}.
    assign dest_x_s = pe_pkt[P_W-1 -: X_AW];
    assign dest_y_s = pe_pkt[P_W-X_AW-1 -: Y_AW];
    assign self_s   = (dest_x_s == X_AW'(X_POS)) && (dest_y_s == Y_AW'(Y_POS));

    // Ready and valid come only from the occupancy register, never from sw_rdy.
    assign pe_rdy   = (occ_s != OCC_W'(DEPTH));
    assign sw_vld   = (occ_s != {OCC_W{1'b0}});
    assign accept_s = pe_vld & pe_rdy;
    assign push_s   = accept_s & ~self_s;
    assign pop_s    = sw_vld & sw_rdy;
    assign stall_s  = sw_vld & ~sw_rdy;

    pe_fifo #(
        .P_W   (P_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .wr_data   (pe_pkt),
        .rd_data   (head_s),
        .occupancy (occ_s)
    );

    // Present the head entry only while valid so stale storage never leaks out.
    always_comb begin
        sw_pkt = {P_W{1'b0}};
        if (sw_vld) begin
            sw_pkt = head_s;
        end else begin
            sw_pkt = {P_W{1'b0}};
        end
    end

    // Loopback register: one-cycle pulse carrying the self-addressed packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_vld_r <= 1'b0;
            lb_pkt_r <= {P_W{1'b0}};
        end else begin
            lb_vld_r <= accept_s & self_s;
            if (accept_s && self_s) begin
                lb_pkt_r <= pe_pkt;
            end
        end
    end

    // Saturating injection and stall statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_cnt_r   <= {CNT_W{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (pop_s && (inj_cnt_r != {CNT_W{1'b1}})) begin
                inj_cnt_r <= inj_cnt_r + CNT_W'(1);
            end
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
        end
    end

    assign lb_pkt    = lb_pkt_r;
    assign lb_vld    = lb_vld_r;
    assign occupancy = occ_s;
    assign inj_cnt   = inj_cnt_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pe_inj_queue.sv
// Directed bench for pe_inj_queue (default parameters, PE at 0,0, DEPTH 4).
module tb_pe_inj_queue;

    logic        clk;
    logic        rst_n;
    logic [15:0] pe_pkt;
    logic        pe_vld;
    logic        pe_rdy;
    logic [15:0] sw_pkt;
    logic        sw_vld;
    logic        sw_rdy;
    logic [15:0] lb_pkt;
    logic        lb_vld;
    logic [2:0]  occupancy;
    logic [15:0] inj_cnt;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] pk [5];

    pe_inj_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pe_pkt    (pe_pkt),
        .pe_vld    (pe_vld),
        .pe_rdy    (pe_rdy),
        .sw_pkt    (sw_pkt),
        .sw_vld    (sw_vld),
        .sw_rdy    (sw_rdy),
        .lb_pkt    (lb_pkt),
        .lb_vld    (lb_vld),
        .occupancy (occupancy),
        .inj_cnt   (inj_cnt),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pk[0] = 16'h4001;
        pk[1] = 16'h8002;
        pk[2] = 16'hC003;
        pk[3] = 16'h1004;
        pk[4] = 16'h2005;

        rst_n  = 1'b0;
        pe_pkt = 16'h0000;
        pe_vld = 1'b0;
        sw_rdy = 1'b0;
        tick();
        tick();
        chk("rst_pe_rdy", 32'(pe_rdy), 32'd1);
        chk("rst_sw_vld", 32'(sw_vld), 32'd0);
        chk("rst_sw_pkt", 32'(sw_pkt), 32'h0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_inj", 32'(inj_cnt), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_lb_vld", 32'(lb_vld), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_sw_vld", 32'(sw_vld), 32'd0);

        // Single push then immediate pop.
        pe_pkt = 16'h5ABC;
        pe_vld = 1'b1;
        sw_rdy = 1'b1;
        tick();
        pe_vld = 1'b0;
        chk("t2_sw_vld", 32'(sw_vld), 32'd1);
        chk("t2_sw_pkt", 32'(sw_pkt), 32'h5ABC);
        chk("t2_occ", 32'(occupancy), 32'd1);
        tick();
        chk("t2_inj", 32'(inj_cnt), 32'd1);
        chk("t2_sw_vld_after", 32'(sw_vld), 32'd0);
        chk("t2_stall", 32'(stall_cnt), 32'd0);

        // Fill while the switch blocks injection.
        sw_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pe_pkt = pk[i];
            pe_vld = 1'b1;
            chk("t3_pe_rdy_fill", 32'(pe_rdy), 32'd1);
            tick();
        end
        pe_pkt = pk[4];
        chk("t3_occ_full", 32'(occupancy), 32'd4);
        chk("t3_pe_rdy_full", 32'(pe_rdy), 32'd0);
        chk("t3_stall_3", 32'(stall_cnt), 32'd3);
        chk("t3_head", 32'(sw_pkt), 32'(pk[0]));
        tick();
        tick();
        chk("t3_hold_occ", 32'(occupancy), 32'd4);
        chk("t3_hold_head", 32'(sw_pkt), 32'(pk[0]));
        chk("t3_stall_5", 32'(stall_cnt), 32'd5);

        // Full with pe_vld and sw_rdy together: pop only.
        sw_rdy = 1'b1;
        tick();
        chk("t4_occ_3", 32'(occupancy), 32'd3);
        chk("t4_head", 32'(sw_pkt), 32'(pk[1]));
        chk("t4_pe_rdy", 32'(pe_rdy), 32'd1);
        chk("t4_inj", 32'(inj_cnt), 32'd2);
        chk("t4_stall", 32'(stall_cnt), 32'd5);
        tick();
        pe_vld = 1'b0;
        chk("t4_both_occ", 32'(occupancy), 32'd3);
        for (int i = 2; i < 5; i++) begin
            chk("t3_order", 32'(sw_pkt), 32'(pk[i]));
            chk("t3_drain_occ", 32'(occupancy), 32'(5 - i));
            tick();
        end
        chk("t3_empty", 32'(sw_vld), 32'd0);
        chk("t3_empty_pkt", 32'(sw_pkt), 32'h0);
        chk("t3_inj", 32'(inj_cnt), 32'd6);
        chk("t3_stall_final", 32'(stall_cnt), 32'd5);

        // Self-addressed packet goes to loopback.
        sw_rdy = 1'b0;
        pe_pkt = 16'h0123;
        pe_vld = 1'b1;
        tick();
        pe_vld = 1'b0;
        chk("t5_lb_vld", 32'(lb_vld), 32'd1);
        chk("t5_lb_pkt", 32'(lb_pkt), 32'h0123);
        chk("t5_sw_vld", 32'(sw_vld), 32'd0);
        chk("t5_occ", 32'(occupancy), 32'd0);
        chk("t5_inj", 32'(inj_cnt), 32'd6);
        tick();
        chk("t5_lb_pulse", 32'(lb_vld), 32'd0);

        // Reset mid-stream with three packets queued.
        for (int i = 0; i < 3; i++) begin
            pe_pkt = pk[i];
            pe_vld = 1'b1;
            tick();
        end
        pe_vld = 1'b0;
        chk("t6_occ_3", 32'(occupancy), 32'd3);
        chk("t6_stall", 32'(stall_cnt), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sw_vld", 32'(sw_vld), 32'd0);
        chk("t6_rst_occ", 32'(occupancy), 32'd0);
        chk("t6_rst_inj", 32'(inj_cnt), 32'd0);
        chk("t6_rst_stall", 32'(stall_cnt), 32'd0);
        tick();
        rst_n  = 1'b1;
        pe_pkt = 16'h7777;
        pe_vld = 1'b1;
        sw_rdy = 1'b1;
        tick();
        pe_vld = 1'b0;
        chk("t6_fresh_pkt", 32'(sw_pkt), 32'h7777);
        chk("t6_fresh_occ", 32'(occupancy), 32'd1);
        tick();
        chk("t6_fresh_inj", 32'(inj_cnt), 32'd1);
        chk("t6_fresh_empty", 32'(occupancy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
